// File: rtl/dac_sample_packer_if.sv
// Upstream sample-beat stream into the DAC packer: one beat is one time instant
// for both channels, packed {ch1_q, ch1_i, ch0_q, ch0_i}.
interface dac_sample_packer_if #(
  parameter int DW = 12
);
  logic            s_valid;
  logic [4*DW-1:0] s_data;
  logic            s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/dac_sample_packer.sv
// Packs pairs of upstream beats into the two-sample-per-channel words consumed
// by the AD9361 DAC interface on each dac_valid strobe, with underflow tracking.
module dac_sample_packer #(
  parameter int DW             = 12,
  parameter bit UNDERFLOW_ZERO = 1'b1
) (
  input  logic                rf_clk,
  input  logic                rstn,
  input  logic                enable,
  dac_sample_packer_if.slave  up,
  input  logic                dac_valid,
  output logic [DW-1:0]       dac0_data0_i,
  output logic [DW-1:0]       dac0_data0_q,
  output logic [DW-1:0]       dac0_data1_i,
  output logic [DW-1:0]       dac0_data1_q,
  output logic [DW-1:0]       dac1_data0_i,
  output logic [DW-1:0]       dac1_data0_q,
  output logic [DW-1:0]       dac1_data1_i,
  output logic [DW-1:0]       dac1_data1_q,
  output logic                underflow,
  output logic [15:0]         underflow_cnt,
  input  logic                clr_underflow
);

  localparam int BW = 4 * DW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [BW-1:0] d1;
    logic [BW-1:0] d0;
  } pair_t;

  state_t        state;
  logic          phase;
  logic [BW-1:0] half;
  pair_t         fifo [2];
  logic [1:0]    cnt;
  logic          rd_ptr;
  logic          wr_ptr;
  pair_t         out_q;
  logic          ready_q;
  logic          underflow_q;
  logic [15:0]   ucnt_q;

  logic          beat;
  logic          push;
  logic          pop;
  logic          uflow;
  logic [1:0]    cnt_next;

  // ready_q comes only from registered count, so dac_valid never reaches s_ready
  // combinationally; enable gates it so a disabled block refuses beats at once.
  assign up.s_ready = enable & ready_q;

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    beat     = up.s_valid & up.s_ready;
    push     = beat & phase;
    pop      = enable & dac_valid & (state != IDLE) & (cnt != 2'd0);
    uflow    = enable & dac_valid & (state == RUN) & (cnt == 2'd0);
    cnt_next = cnt + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: the half-beat and pair storage are data only, qualified by phase and
  // cnt, so they carry no reset and map cleanly onto plain flops/RAM.
  always_ff @(posedge rf_clk) begin
    if (beat && !phase) half <= up.s_data;
    if (push)           fifo[wr_ptr] <= {up.s_data, half};
  end

  always_ff @(posedge rf_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      phase       <= 1'b0;
      cnt         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      out_q       <= '0;
      ready_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!enable) begin
      // Flush: any buffered pair and any half-assembled pair are dropped.
      state       <= IDLE;
      phase       <= 1'b0;
      cnt         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      out_q       <= '0;
      ready_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      ready_q     <= (cnt_next != 2'd2);
      underflow_q <= uflow;
      if (beat) phase  <= ~phase;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        out_q  <= fifo[rd_ptr];
      end
      if (uflow && UNDERFLOW_ZERO) out_q <= '0;

      case (state)
        IDLE:    state <= PRIME;
        PRIME:   if (pop) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Clear wins over a coincident underflow; the count sticks at all-ones.
  always_ff @(posedge rf_clk or negedge rstn) begin
    if (!rstn)                          ucnt_q <= 16'd0;
    else if (clr_underflow)             ucnt_q <= 16'd0;
    else if (uflow && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end

  assign dac0_data0_i  = out_q.d0[DW-1:0];
  assign dac0_data0_q  = out_q.d0[2*DW-1:DW];
  assign dac1_data0_i  = out_q.d0[3*DW-1:2*DW];
  assign dac1_data0_q  = out_q.d0[4*DW-1:3*DW];
  assign dac0_data1_i  = out_q.d1[DW-1:0];
  assign dac0_data1_q  = out_q.d1[2*DW-1:DW];
  assign dac1_data1_i  = out_q.d1[3*DW-1:2*DW];
  assign dac1_data1_q  = out_q.d1[4*DW-1:3*DW];
  assign underflow     = underflow_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_dac_sample_packer.sv
// Bench for dac_sample_packer: two instances (zero-fill and repeat-last) share
// one stimulus stream and are checked against a queue-based pair model.
module tb_dac_sample_packer;

  localparam int DW = 12;
  localparam int BW = 4 * DW;
  localparam int PW = 2 * BW;

  logic          rf_clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          dac_valid;
  logic          clr_underflow;
  logic          s_valid;
  logic [BW-1:0] s_data;

  logic [7:0][DW-1:0] o0, o1;
  logic               uf0, uf1;
  logic [15:0]        uc0, uc1;

  dac_sample_packer_if #(.DW(DW)) if0 ();
  dac_sample_packer_if #(.DW(DW)) if1 ();

  assign if0.s_valid = s_valid;
  assign if0.s_data  = s_data;
  assign if1.s_valid = s_valid;
  assign if1.s_data  = s_data;

  always #5 rf_clk = ~rf_clk;

  dac_sample_packer #(.DW(DW), .UNDERFLOW_ZERO(1'b1)) dut0 (
    .rf_clk(rf_clk), .rstn(rstn), .enable(enable), .up(if0), .dac_valid(dac_valid),
    .dac0_data0_i(o0[0]), .dac0_data0_q(o0[1]), .dac1_data0_i(o0[2]), .dac1_data0_q(o0[3]),
    .dac0_data1_i(o0[4]), .dac0_data1_q(o0[5]), .dac1_data1_i(o0[6]), .dac1_data1_q(o0[7]),
    .underflow(uf0), .underflow_cnt(uc0), .clr_underflow(clr_underflow)
  );

  dac_sample_packer #(.DW(DW), .UNDERFLOW_ZERO(1'b0)) dut1 (
    .rf_clk(rf_clk), .rstn(rstn), .enable(enable), .up(if1), .dac_valid(dac_valid),
    .dac0_data0_i(o1[0]), .dac0_data0_q(o1[1]), .dac1_data0_i(o1[2]), .dac1_data0_q(o1[3]),
    .dac0_data1_i(o1[4]), .dac0_data1_q(o1[5]), .dac1_data1_i(o1[6]), .dac1_data1_q(o1[7]),
    .underflow(uf1), .underflow_cnt(uc1), .clr_underflow(clr_underflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: completed pairs as {second beat, first beat} in a queue,
  // a pending first beat, and the expected presented pair for each variant.
  logic [PW-1:0] mq [$];
  logic [BW-1:0] m_half;
  bit            m_have;
  int            m_state;       // 0 idle, 1 priming, 2 running
  logic [PW-1:0] m_out_z;
  logic [PW-1:0] m_out_r;
  bit            m_uf;
  logic [15:0]   m_ucnt;
  bit            m_armed;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_have  = 1'b0;
    m_state = 0;
    m_out_z = '0;
    m_out_r = '0;
    m_uf    = 1'b0;
    m_ucnt  = 16'd0;
    m_armed = 1'b0;
  endtask

  task automatic model_edge();
    bit            pop_ok, ufl, acc;
    logic [PW-1:0] head;
    ufl = 1'b0;
    if (!enable) begin
      m_state = 0;
      mq.delete();
      m_have  = 1'b0;
      m_out_z = '0;
      m_out_r = '0;
      m_uf    = 1'b0;
    end else begin
      acc    = s_valid && m_armed && (mq.size() < 2);
      pop_ok = dac_valid && (m_state != 0) && (mq.size() > 0);
      ufl    = dac_valid && (m_state == 2) && (mq.size() == 0);
      if (pop_ok) begin
        head    = mq.pop_front();
        m_out_z = head;
        m_out_r = head;
      end
      if (ufl) m_out_z = '0;
      m_uf = ufl;
      if (acc) begin
        if (m_have) begin
          mq.push_back({s_data, m_half});
          m_have = 1'b0;
        end else begin
          m_half = s_data;
          m_have = 1'b1;
        end
      end
      if (m_state == 0)                m_state = 1;
      else if (m_state == 1 && pop_ok) m_state = 2;
    end
    if (clr_underflow)                    m_ucnt = 16'd0;
    else if (ufl && m_ucnt != 16'hFFFF)   m_ucnt = m_ucnt + 16'd1;
    m_armed = 1'b1;
  endtask

  // One rf_clk cycle: drive at the falling edge, check ready before the rising
  // edge, advance the model on it, check outputs at the next falling edge.
  task automatic cyc(input bit v, input logic [BW-1:0] d, input bit dv, input bit clr = 1'b0);
    s_valid       = v;
    s_data        = d;
    dac_valid     = dv;
    clr_underflow = clr;
    #1;
    chk("s_ready0", if0.s_ready, enable && m_armed && (mq.size() < 2));
    chk("s_ready1", if1.s_ready, enable && m_armed && (mq.size() < 2));
    @(posedge rf_clk);
    model_edge();
    @(negedge rf_clk);
    chk("pair_zero", o0, m_out_z);
    chk("pair_rep",  o1, m_out_r);
    chk("uflow0",    uf0, m_uf);
    chk("uflow1",    uf1, m_uf);
    chk("ucnt0",     uc0, m_ucnt);
    chk("ucnt1",     uc1, m_ucnt);
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom(), $urandom()} & {BW{1'b1}};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BW-1:0] n1, n2;
    logic [PW-1:0] prior;
    int            since;

    rstn = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    dac_valid = 1'b0; clr_underflow = 1'b0;
    model_reset();
    repeat (2) @(negedge rf_clk);
    chk("rst_pair",  o0, '0);
    chk("rst_ready", if0.s_ready, 1'b0);
    chk("rst_uflow", uf0, 1'b0);
    chk("rst_ucnt",  uc0, 16'd0);
    chk("rst_state", dut0.state, 2'd0);
    rstn = 1'b1;
    cyc(0, '0, 0);

    // First two beats become data0/data1 of the first presented pair.
    enable = 1'b1;
    cyc(1, 48'h004003002001, 0);
    cyc(1, 48'h008007006005, 0);
    cyc(0, '0, 1);
    chk("a_d0i0", o0[0], 12'h001);
    chk("a_d0q0", o0[1], 12'h002);
    chk("a_d1i0", o0[2], 12'h003);
    chk("a_d1q0", o0[3], 12'h004);
    chk("a_d0i1", o0[4], 12'h005);
    chk("a_d1q1", o0[7], 12'h008);
    chk("a_state", dut0.state, 2'd2);

    // Backpressure: two full pairs stall the upstream until one is consumed.
    repeat (4) cyc(1, rnd_beat(), 0);
    #1 chk("full_ready", if0.s_ready, 1'b0);
    cyc(1, rnd_beat(), 1);
    chk("ready_back", if0.s_ready, 1'b1);
    cyc(0, '0, 0);

    // Drain, then strobe with nothing buffered.
    cyc(0, '0, 1);
    prior = m_out_r;
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    chk("uf_pulse", uf0, 1'b1);
    chk("uf_zero",  o0, '0);
    chk("uf_rep",   o1, prior);
    chk("uf_cnt",   uc0, 16'd1);
    cyc(0, '0, 0);
    chk("uf_once",  uf0, 1'b0);

    // Saturation and clear-over-increment.
    force dut0.ucnt_q = 16'hFFFE;
    force dut1.ucnt_q = 16'hFFFE;
    #1;
    release dut0.ucnt_q;
    release dut1.ucnt_q;
    m_ucnt = 16'hFFFE;
    repeat (3) begin
      cyc(0, '0, 1);
      cyc(0, '0, 0);
    end
    chk("sat_cnt", uc0, 16'hFFFF);
    cyc(0, '0, 1, 1);
    chk("clr_cnt", uc0, 16'd0);
    cyc(0, '0, 0);

    // Disable with one pair and a half buffered; nothing stale may survive.
    repeat (3) cyc(1, rnd_beat(), 0);
    enable = 1'b0;
    cyc(0, '0, 0);
    #1;
    chk("flush_ready", if0.s_ready, 1'b0);
    chk("flush_pair",  o0, '0);
    chk("flush_state", dut0.state, 2'd0);
    enable = 1'b1;
    n1 = rnd_beat();
    n2 = rnd_beat();
    cyc(1, n1, 0);
    cyc(1, n2, 0);
    cyc(0, '0, 1);
    chk("fresh_pair", o0, {n2, n1});

    // Randomised traffic, strobes at least two cycles apart.
    since = 9;
    for (int i = 0; i < 600; i++) begin
      bit dv;
      enable = ($urandom_range(63) != 0);
      dv     = (since >= 2) && ($urandom_range(2) == 0);
      since  = dv ? 1 : since + 1;
      cyc(($urandom_range(3) != 0), rnd_beat(), dv, ($urandom_range(49) == 0));
    end

    // Asynchronous reset mid-stream, asserted between clock edges.
    enable = 1'b1;
    repeat (3) cyc(1, rnd_beat(), 0);
    cyc(1, rnd_beat(), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_pair0", o0, '0);
    chk("arst_pair1", o1, '0);
    chk("arst_ready", if0.s_ready, 1'b0);
    chk("arst_uflow", uf0, 1'b0);
    chk("arst_ucnt",  uc0, 16'd0);
    chk("arst_state", dut0.state, 2'd0);
    model_reset();
    @(posedge rf_clk);
    @(negedge rf_clk);
    rstn = 1'b1;
    repeat (2) cyc(1, rnd_beat(), 0);
    cyc(0, '0, 1);
    repeat (20) cyc(1, rnd_beat(), ($urandom_range(3) == 0) && !dac_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_sample_packer.md
DAC_SAMPLE_PACKER -- requirements
Module: dac_sample_packer

Interface
REQ-001 SHALL have parameter DW, default 12, giving the width of each I or Q sample in bits.
REQ-002 SHALL have parameter UNDERFLOW_ZERO, default 1: 1 = drive zeros on underflow, 0 = repeat the last pair.
REQ-003 SHALL have port rf_clk, input, 1 bit: the single clock, the same clock that drives the AD9361 interface dac_valid.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset (fixed).
REQ-005 SHALL have port enable, input, 1 bit: level-sensitive datapath enable.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream beat valid.
REQ-007 SHALL have port s_data, input, 4*DW bits: one time instant packed as {ch1_q, ch1_i, ch0_q, ch0_i}, with ch0_i in the LSBs.
REQ-008 SHALL have port s_ready, output, 1 bit: upstream beat ready.
REQ-009 SHALL have port dac_valid, input, 1 bit: one-cycle consume strobe from the interface, nominally every 4th rf_clk cycle.
REQ-010 SHALL have ports dac0_data0_i, dac0_data0_q, dac0_data1_i, dac0_data1_q, dac1_data0_i, dac1_data0_q, dac1_data1_i and dac1_data1_q, outputs, DW bits each: the presented sample pair.
REQ-011 SHALL have port underflow, output, 1 bit: one-cycle underflow pulse.
REQ-012 SHALL have port underflow_cnt, output, 16 bits: saturating underflow count.
REQ-013 SHALL have port clr_underflow, input, 1 bit: synchronous clear of underflow_cnt.

Function
REQ-014 SHALL transfer a beat on every cycle in which s_valid and s_ready are both 1; s_data SHALL be ignored otherwise.
REQ-015 SHALL assemble beats into pairs: the first beat SHALL become data0 and the second SHALL become data1; a phase bit SHALL track the half pair.
REQ-016 SHALL buffer completed pairs in a 2-entry pair FIFO with a count of 0..2.
REQ-017 SHALL drive s_ready = enable AND (pair count < 2), decoded from registered state only, with no combinational path from dac_valid.
REQ-018 SHALL keep the count unchanged when a pair completes and a pair pops in the same cycle, and the FIFO SHALL never overflow or underflow internally.
REQ-019 SHALL use a state machine with states IDLE, PRIME and RUN.
REQ-020 SHALL move IDLE -> PRIME on enable = 1.
REQ-021 In PRIME, SHALL on dac_valid with count >= 1 pop the head into the outputs and move to RUN.
REQ-022 In PRIME, SHALL on dac_valid with count = 0 stay in PRIME, with outputs zero and no underflow.
REQ-023 In RUN, SHALL on dac_valid with count >= 1 load the outputs from the FIFO head one cycle after the strobe and pop it.
REQ-024 In RUN, SHALL on dac_valid with count = 0 pulse underflow for exactly 1 cycle, with the outputs set per UNDERFLOW_ZERO on the next cycle.
REQ-025 SHALL hold the outputs stable in all cycles except the one following a dac_valid in RUN or a PRIME load.
REQ-026 SHALL, on enable = 0 in any state, go to IDLE on the next cycle, flush the FIFO, clear phase, zero the outputs and keep s_ready at 0.
REQ-027 SHALL discard a half-assembled pair on the flush.
REQ-028 SHALL increment underflow_cnt on each underflow pulse and saturate it at 16'hFFFF.
REQ-029 SHALL clear underflow_cnt to 0 on clr_underflow, with clear winning over a simultaneous increment.
REQ-030 SHALL place no constraint on dac_valid spacing, but SHALL guarantee correctness only for a spacing of at least 2 cycles.

Reset
REQ-031 SHALL asynchronously, while rstn = 0, set the state to IDLE, count and phase to 0, all eight data outputs to 0, s_ready to 0, underflow to 0 and underflow_cnt to 0.
REQ-032 SHALL release reset synchronously, with the first state update occurring on the first rf_clk edge after rstn = 1.
REQ-033 SHALL, on rstn assertion mid-operation, apply the reset state immediately and lose any buffered data.

Verification
REQ-034 Bench SHALL cover: enable = 1, beats A = 0x004003002001 then B = 0x008007006005, then dac_valid -> next cycle dac0_data0_i = 0x001, dac0_data0_q = 0x002, dac1_data0_i = 0x003, dac1_data0_q = 0x004, dac0_data1_i = 0x005, dac1_data1_q = 0x008, state RUN.
REQ-035 Bench SHALL cover: s_valid held at 1 and no dac_valid -> s_ready falls to 0 after 4 beats (2 pairs); one dac_valid then restores s_ready = 1 on the next cycle.
REQ-036 Bench SHALL cover: RUN with an empty FIFO, dac_valid, UNDERFLOW_ZERO = 1 -> underflow = 1 for 1 cycle, outputs 0, underflow_cnt = 1; with UNDERFLOW_ZERO = 0 -> outputs repeat the prior pair.
REQ-037 Bench SHALL cover: underflow_cnt forced to 0xFFFE plus 3 underflows -> count reads 0xFFFF; clr_underflow coincident with an underflow -> count reads 0.
REQ-038 Bench SHALL cover: enable dropped after 3 beats (1 pair plus a half) -> next cycle s_ready = 0 and outputs 0; after re-enable, 2 new beats form the first output pair with no stale data.
REQ-039 Bench SHALL cover: rstn pulsed low mid-stream, asynchronously between clock edges -> all outputs 0 immediately and state IDLE.
